iowrite: RTL and testbench

- CPU-to-output-device write port; the output counterpart of the switch input path.
- Captures CPU store data into a 16-bit LED register and a 32-bit seven-segment display register.
- Time-multiplexes the 8-digit seven-segment display with a scan counter.
- Returns a one-cycle write-complete flag to memorio.

---
 rtl/iowrite_if.sv | 20 ++
 rtl/iowrite.sv | 101 ++++++++++
 tb/tb_iowrite.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iowrite_if.sv
// CPU-side write bus into the output-device port: strobe, target selects,
// store data, and the returned write-complete pulse.
interface iowrite_if;
  logic        iow;
  logic        ledCtrl1;
  logic        ledCtrl2;
  logic        segCtrl;
  logic [31:0] iowrite_data;
  logic        isIOWriteOK;

  modport master (
    output iow, ledCtrl1, ledCtrl2, segCtrl, iowrite_data,
    input  isIOWriteOK
  );

  modport slave (
    input  iow, ledCtrl1, ledCtrl2, segCtrl, iowrite_data,
    output isIOWriteOK
  );
endinterface

// File: rtl/iowrite.sv
// Output-device write port: LED register, 32-bit seven-segment value register
// and an 8-digit time-multiplexed display scan.
module iowrite #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  iowrite_if.slave    bus,
  output logic [15:0] led,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      seg_value;
  logic             seg_valid;
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       digit_idx;
  logic             wr_accept;
  logic [3:0]       cur_nibble;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    wr_accept  = bus.iow & (bus.ledCtrl1 | bus.ledCtrl2 | bus.segCtrl);
    cur_nibble = seg_value[{digit_idx, 2'b00} +: 4];
  end

  // Write capture: one target per accepted cycle, ledCtrl1 > ledCtrl2 > segCtrl.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led             <= 16'h0000;
      seg_value       <= 32'h0000_0000;
      seg_valid       <= 1'b0;
      bus.isIOWriteOK <= 1'b0;
    end else begin
      bus.isIOWriteOK <= wr_accept;
      if (bus.iow) begin
        if (bus.ledCtrl1) begin
          led[15:8] <= bus.iowrite_data[7:0];
        end else if (bus.ledCtrl2) begin
          led[7:0] <= bus.iowrite_data[7:0];
        end else if (bus.segCtrl) begin
          seg_value <= bus.iowrite_data;
          seg_valid <= 1'b1;
        end
      end
    end
  end

  // Scan timing: free-running dwell counter steps the digit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Display register: reflects the pre-edge index and value, so it trails by a cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else if (seg_valid) begin
      seg_en  <= ~(8'b0000_0001 << digit_idx);
      seg_out <= seg_decode(cur_nibble);
    end else begin
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_iowrite.sv
// Scoreboard bench for iowrite: a cycle-count reference model queues the
// expected outputs, a monitor compares them after each rising edge.
module tb_iowrite;

  localparam int SD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] led;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  iowrite_if bus ();

  iowrite #(.SCAN_DIV(SD)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .led     (led),
    .seg_en  (seg_en),
    .seg_out (seg_out)
  );

  typedef struct packed {
    logic [15:0] led;
    logic [7:0]  en;
    logic [7:0]  out;
    logic        ok;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: registers plus the number of clocked cycles since reset.
  logic [15:0] m_led;
  logic [31:0] m_val;
  logic        m_valid;
  int          m_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic rst_n, input logic iow, input logic c1, input logic c2,
                      input logic sc, input logic [31:0] data);
    exp_t e;
    int   idx;
    @(negedge clk);
    reset            = rst_n;
    bus.iow          = iow;
    bus.ledCtrl1     = c1;
    bus.ledCtrl2     = c2;
    bus.segCtrl      = sc;
    bus.iowrite_data = data;
    if (!rst_n) begin
      m_led = 16'h0; m_val = 32'h0; m_valid = 1'b0; m_n = 0;
      e = '{led: 16'h0, en: 8'hFF, out: 8'hFF, ok: 1'b0};
    end else begin
      idx = (m_n / SD) % 8;
      if (m_valid) begin
        e.en  = ~(8'(1) << idx);
        e.out = seg_tab[(m_val >> (4 * idx)) & 32'hF];
      end else begin
        e.en  = 8'hFF;
        e.out = 8'hFF;
      end
      e.ok = iow && (c1 || c2 || sc);
      if (iow && c1)      m_led[15:8] = data[7:0];
      else if (iow && c2) m_led[7:0]  = data[7:0];
      else if (iow && sc) begin m_val = data; m_valid = 1'b1; end
      e.led = m_led;
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: every rising edge that has a queued expectation gets compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (led !== e.led || seg_en !== e.en || seg_out !== e.out || bus.isIOWriteOK !== e.ok) begin
          miscompares++;
          $display("FAIL outputs @%0t: got led=%h seg_en=%h seg_out=%h ok=%b, want led=%h seg_en=%h seg_out=%h ok=%b",
                   $time, led, seg_en, seg_out, bus.isIOWriteOK, e.led, e.en, e.out, e.ok);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0; bus.iow = 1'b0; bus.ledCtrl1 = 1'b0; bus.ledCtrl2 = 1'b0;
    bus.segCtrl = 1'b0; bus.iowrite_data = 32'h0;
    m_led = 16'h0; m_val = 32'h0; m_valid = 1'b0; m_n = 0;

    // Reset held with a write pending on the bus.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00FF);

    // LED byte writes and priority resolution.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00A5);
    idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_003C);
    idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5677);
    idle(2);

    // Seven-segment write and a full scan sweep.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0123_ABCD);
    idle(40);

    // Ignored cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    idle(2);

    // Held write: continuous acks.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'(8'h10 + i));
    idle(1);

    // Reset in the middle of a scan at digit 5.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h89AB_CDEF);
    guard = 0;
    while (((m_n / SD) % 8) != 5 && guard < 100) begin
      idle(1);
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(12);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
    idle(10);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 63) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), $urandom);
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
